btn_repeat_ctrl: RTL and testbench
==================================

Name: btn_repeat_ctrl

Overview:
- Upstream input-conditioning stage for the PWM duty-cycle block.
- Takes the raw increment and decrement push buttons and synchronises and debounces both, press and release.
- Emits single-cycle step pulses: one per accepted press, then auto-repeat pulses while the button is held.
- The PWM stage consumes `incr_pulse` / `decr_pulse` as one-step duty-cycle commands.

Parameters:
- DEBOUNCE_CYCLES, 512: consecutive stable synchronised cycles needed to accept a press or a release.
- REPEAT_DELAY, 6250: cycles from the first pulse to the first auto-repeat pulse (0.5 s at 12.5 kHz).
- REPEAT_PERIOD, 1250: cycles between successive auto-repeat pulses (0.1 s at 12.5 kHz).
- CNT_W, 16: width of each per-channel counter. Must satisfy 2^CNT_W > max of the three values above.

Ports:
- clk  in  1  system clock (12.5 kHz nominal).
- rst  in  1  asynchronous, active-high reset.
- btn_incr_raw  in  1  raw increment button, asynchronous, active-high.
- btn_decr_raw  in  1  raw decrement button, asynchronous, active-high.
- repeat_en  in  1  1 = auto-repeat enabled; 0 = exactly one pulse per press.
- incr_pulse  out  1  one-cycle increment command.
- decr_pulse  out  1  one-cycle decrement command.
- incr_held  out  1  increment press accepted and not yet release-debounced.
- decr_held  out  1  decrement press accepted and not yet release-debounced.

Behaviour:
- Reset:
  - Clock and reset are decided: one clock, `clk`; reset `rst` is asynchronous and active-high.
  - On reset, all outputs are 0, both synchronisers are 0, both FSMs are IDLE and all counters are 0.
  - Reset mid-press drops any pending pulse. After reset releases, a still-held button needs a full fresh debounce before it can pulse.
- Synchroniser: two flops per button. A raw level sampled at edge 1 appears on `sync` after edge 2.
- Per-channel FSM, all transitions on `clk`, counter `cnt`:
  - IDLE: if `sync`=1, go to PRESS_DB with cnt=0.
  - PRESS_DB:
    - if `sync`=0, go to IDLE;
    - else if cnt==DEBOUNCE_CYCLES-1, go to HOLD, set cnt=0, raw pulse=1;
    - else cnt+1.
  - HOLD:
    - if `sync`=0, go to REL_DB with cnt=0;
    - else if repeat_en and cnt==REPEAT_DELAY-1, go to REPEAT, set cnt=0, raw pulse=1;
    - else cnt+1, saturating at REPEAT_DELAY-1 when repeat_en=0.
  - REPEAT:
    - if `sync`=0, go to REL_DB with cnt=0;
    - else if repeat_en=0, go to HOLD with cnt=0;
    - else if cnt==REPEAT_PERIOD-1, pulse=1 and cnt=0;
    - else cnt+1.
  - REL_DB:
    - if `sync`=1, go to HOLD with cnt=0 and no pulse (release bounce is ignored);
    - else if cnt==DEBOUNCE_CYCLES-1, go to IDLE;
    - else cnt+1.
- Channel outputs:
  - Raw pulse is registered and high for exactly one cycle.
  - `held`=1 in HOLD, REPEAT and REL_DB.
- First-pulse latency: the raw pulse is high in the cycle after edge DEBOUNCE_CYCLES+3, where edge 1 is the first edge sampling raw=1 and the button is held stable. With default parameters this is edge 515.
- Auto-repeat timing: first repeat is REPEAT_DELAY cycles after the first pulse; subsequent repeats follow every REPEAT_PERIOD cycles.
- Conflict rule (top level, combinational on registered signals):
  - incr_pulse = incr_raw_pulse & ~decr_held & ~decr_raw_pulse;
  - decr_pulse mirrors this.
  - Simultaneous pulses, or a pulse while the other button is held, are suppressed. Both channel FSMs keep running.
  - `held` outputs are never suppressed.
- Invariants: incr_pulse and decr_pulse are never high together; no pulse is ever longer than 1 cycle.

Decomposition:
- Shared package `btn_pkg` holds:
  - state enum {IDLE, PRESS_DB, HOLD, REPEAT, REL_DB};
  - default parameter constants;
  - the function clog2 used to range-check CNT_W.
- Sub-module `btn_channel`:
  - one instance per button;
  - contains the synchroniser, FSM and counter;
  - ports: clk, rst, btn_raw, repeat_en, pulse, held.
- The top instantiates two channels plus the conflict gating.

Test Plan:
All scenarios except 5 use DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=10.
1. btn_incr_raw high from edge 1, held 100 cycles, repeat_en=1 -> incr_pulse high after edge 11 only, then at edges 51, 61, 71, 81, 91, 101; incr_held rises after edge 11; decr outputs stay 0.
2. btn_decr_raw toggles every 3 cycles for 30 cycles, then stays 0 -> no decr_pulse and decr_held stays 0; FSM returns to IDLE.
3. incr held, then a 4-cycle low glitch at cycle 20 -> no extra pulse; incr_held stays 1 throughout; release held low for ≥8 synchronised cycles -> incr_held falls.
4. Both raws rise at the same edge and are held 30 cycles -> incr_pulse=decr_pulse=0 in every cycle; both held outputs =1.
5. repeat_en=0 with default parameters, incr held for 10000 cycles -> exactly one incr_pulse, after edge 515.
6. Assert rst for 2 cycles in mid-REPEAT with the button still held -> all outputs 0 immediately; next pulse comes 11 edges after rst deasserts.

Source files
------------

// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button auto-repeat controller:
//   - btn_state_t : per-channel FSM state encoding
//   - DEF_*       : default timing constants (12.5 kHz system clock)
//   - clog2()     : ceiling log2, used to range-check the counter width
// ---------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HOLD     = 3'd2,
        REPEAT   = 3'd3,
        REL_DB   = 3'd4
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 512;
    localparam int DEF_REPEAT_DELAY    = 6250;
    localparam int DEF_REPEAT_PERIOD   = 1250;
    localparam int DEF_CNT_W           = 16;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input longint unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// ---------------------------------------------------------------------------
// btn_channel
// One push-button conditioning channel: two-flop synchroniser, press/release
// debounce and auto-repeat pulse generation with a single shared counter.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   btn_raw    in   raw (asynchronous) button level, active-high
//   repeat_en  in   1 = auto-repeat while held, 0 = one pulse per press
//   pulse      out  registered one-cycle step pulse
//   held       out  press accepted and release not yet debounced
//
// State table:
//   state    | meaning
//   IDLE     | button released, waiting for sync=1
//   PRESS_DB | counting stable-high cycles before accepting the press
//   HOLD     | press accepted, timing the initial repeat delay
//   REPEAT   | auto-repeating, one pulse every REPEAT_PERIOD cycles
//   REL_DB   | counting stable-low cycles before accepting the release
// ---------------------------------------------------------------------------
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             sync_meta;
    logic             btn_sync;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pulse_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            btn_sync  <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            btn_sync  <= sync_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_nxt = PRESS_DB;
                    cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (!btn_sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HOLD: begin
                if (!btn_sync) begin
                    state_nxt = REL_DB;
                    cnt_nxt   = '0;
                end else if (repeat_en && (cnt == DELAY_LAST)) begin
                    state_nxt = REPEAT;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else if (cnt != DELAY_LAST) begin
                    // Saturates when repeat is off, so re-enabling repeat
                    // after a long hold fires on the next cycle.
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            REPEAT: begin
                if (!btn_sync) begin
                    state_nxt = REL_DB;
                    cnt_nxt   = '0;
                end else if (!repeat_en) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else if (cnt == PERIOD_LAST) begin
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            REL_DB: begin
                // A short high during release is bounce: back to HOLD with
                // the repeat delay restarted and no new pulse.
                if (btn_sync) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign held = (state == HOLD) || (state == REPEAT) || (state == REL_DB);

endmodule

// File: rtl/btn_repeat_ctrl.sv
// ---------------------------------------------------------------------------
// btn_repeat_ctrl
// Increment/decrement button front end for the PWM duty-cycle block. Each
// button gets a debounce + auto-repeat channel; the outputs are then gated so
// that only one direction can step at a time.
//
// Ports:
//   clk           in   system clock (12.5 kHz nominal)
//   rst           in   asynchronous active-high reset
//   btn_incr_raw  in   raw increment button
//   btn_decr_raw  in   raw decrement button
//   repeat_en     in   auto-repeat enable
//   incr_pulse    out  one-cycle increment command
//   decr_pulse    out  one-cycle decrement command
//   incr_held     out  increment button accepted as held
//   decr_held     out  decrement button accepted as held
// ---------------------------------------------------------------------------
module btn_repeat_ctrl
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_incr_raw,
    input  logic btn_decr_raw,
    input  logic repeat_en,
    output logic incr_pulse,
    output logic decr_pulse,
    output logic incr_held,
    output logic decr_held
);

    localparam int MAX_AB    = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_COUNT = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;

    if (clog2(longint'(MAX_COUNT) + 64'd1) > CNT_W) begin : g_cnt_w_too_small
        $error("btn_repeat_ctrl: CNT_W too narrow for the configured cycle counts");
    end

    logic incr_raw_pulse;
    logic decr_raw_pulse;

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .CNT_W           (CNT_W)
    ) u_incr (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_incr_raw),
        .repeat_en (repeat_en),
        .pulse     (incr_raw_pulse),
        .held      (incr_held)
    );

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .CNT_W           (CNT_W)
    ) u_decr (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_decr_raw),
        .repeat_en (repeat_en),
        .pulse     (decr_raw_pulse),
        .held      (decr_held)
    );

    // Both inputs are registered, so this gating adds no glitch risk. A step
    // is dropped whenever the opposite button is active in any way; the
    // channels themselves keep running so timing resumes undisturbed.
    assign incr_pulse = incr_raw_pulse & ~decr_held & ~decr_raw_pulse;
    assign decr_pulse = decr_raw_pulse & ~incr_held & ~incr_raw_pulse;

endmodule

// File: tb/tb_btn_repeat_ctrl.sv
module tb_btn_repeat_ctrl;

    localparam int D  = 8;
    localparam int RD = 40;
    localparam int RP = 10;

    logic clk = 1'b0;
    logic rst;
    logic btn_incr_raw, btn_decr_raw, repeat_en;
    logic incr_pulse, decr_pulse, incr_held, decr_held;
    logic d_incr_raw, d_decr_raw, d_repeat_en;
    logic d_incr_pulse, d_decr_pulse, d_incr_held, d_decr_held;

    always #5 clk = ~clk;

    btn_repeat_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (16)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .btn_incr_raw (btn_incr_raw),
        .btn_decr_raw (btn_decr_raw),
        .repeat_en    (repeat_en),
        .incr_pulse   (incr_pulse),
        .decr_pulse   (decr_pulse),
        .incr_held    (incr_held),
        .decr_held    (decr_held)
    );

    btn_repeat_ctrl u_dut_def (
        .clk          (clk),
        .rst          (rst),
        .btn_incr_raw (d_incr_raw),
        .btn_decr_raw (d_decr_raw),
        .repeat_en    (d_repeat_en),
        .incr_pulse   (d_incr_pulse),
        .decr_pulse   (d_decr_pulse),
        .incr_held    (d_incr_held),
        .decr_held    (d_decr_held)
    );

    int checks = 0;
    int errors = 0;
    int now    = 0;

    // Reference model: timestamp based. A press is accepted D edges after the
    // synchronised level is first seen high; repeats fire when enough edges
    // have elapsed since the last timing anchor; a release is accepted D edges
    // after the synchronised level is first seen low.
    bit m_s1[2], m_s2[2];
    bit m_held[2], m_rpt[2], m_rel[2], m_run[2], m_pulse[2];
    int m_start[2], m_anchor[2], m_rel_start[2];
    bit exp_incr, exp_decr;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_held[c] = 0; m_rpt[c] = 0;
            m_rel[c] = 0; m_run[c] = 0; m_pulse[c] = 0;
            m_start[c] = 0; m_anchor[c] = 0; m_rel_start[c] = 0;
        end
        exp_incr = 0;
        exp_decr = 0;
    endtask

    task automatic model_channel(input int c, input bit s, input bit rep);
        m_pulse[c] = 0;
        if (!m_held[c]) begin
            if (!s) begin
                m_run[c] = 0;
            end else if (!m_run[c]) begin
                m_run[c]   = 1;
                m_start[c] = now;
            end else if (now - m_start[c] == D) begin
                m_held[c]   = 1;
                m_rpt[c]    = 0;
                m_rel[c]    = 0;
                m_run[c]    = 0;
                m_anchor[c] = now;
                m_pulse[c]  = 1;
            end
        end else if (m_rel[c]) begin
            if (s) begin
                m_rel[c]    = 0;
                m_rpt[c]    = 0;
                m_anchor[c] = now;
            end else if (now - m_rel_start[c] == D) begin
                m_held[c] = 0;
                m_rel[c]  = 0;
            end
        end else if (!s) begin
            m_rel[c]       = 1;
            m_rel_start[c] = now;
        end else if (!m_rpt[c]) begin
            if (rep && (now - m_anchor[c] >= RD)) begin
                m_pulse[c]  = 1;
                m_rpt[c]    = 1;
                m_anchor[c] = now;
            end
        end else begin
            if (!rep) begin
                m_rpt[c]    = 0;
                m_anchor[c] = now;
            end else if (now - m_anchor[c] == RP) begin
                m_pulse[c]  = 1;
                m_anchor[c] = now;
            end
        end
    endtask

    task automatic model_step(input bit raw0, input bit raw1, input bit rep);
        model_channel(0, m_s2[0], rep);
        model_channel(1, m_s2[1], rep);
        m_s2[0] = m_s1[0]; m_s1[0] = raw0;
        m_s2[1] = m_s1[1]; m_s1[1] = raw1;
        exp_incr = m_pulse[0] && !m_held[1] && !m_pulse[1];
        exp_decr = m_pulse[1] && !m_held[0] && !m_pulse[0];
    endtask

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, expv, now);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, expv, now);
        end
    endtask

    task automatic check_outputs();
        check("incr_pulse", incr_pulse, exp_incr);
        check("decr_pulse", decr_pulse, exp_decr);
        check("incr_held", incr_held, m_held[0]);
        check("decr_held", decr_held, m_held[1]);
        check("pulse_exclusive", incr_pulse & decr_pulse, 1'b0);
        check("def_pulse_exclusive", d_incr_pulse & d_decr_pulse, 1'b0);
    endtask

    task automatic cycle();
        @(posedge clk);
        now++;
        if (rst) model_reset();
        else     model_step(btn_incr_raw, btn_decr_raw, repeat_en);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int base;
        int q[$];
        int exp_s1[7];
        int first_held, hits, held_drop, fall_edge, first_pulse, d_cnt, d_edge, seg_len;

        exp_s1 = '{11, 51, 61, 71, 81, 91, 101};

        rst = 1; btn_incr_raw = 0; btn_decr_raw = 0; repeat_en = 1;
        d_incr_raw = 0; d_decr_raw = 0; d_repeat_en = 1;
        model_reset();
        #1;
        check_outputs();
        check("def_reset_incr_held", d_incr_held, 1'b0);
        check("def_reset_incr_pulse", d_incr_pulse, 1'b0);
        idle(2);
        rst = 0;
        idle(3);

        // 1: single press with auto-repeat
        btn_incr_raw = 1; base = now; first_held = -1; hits = 0;
        for (int i = 0; i < 103; i++) begin
            if (i == 100) btn_incr_raw = 0;
            cycle();
            if (incr_pulse) q.push_back(now - base);
            if (incr_held && first_held < 0) first_held = now - base;
            if (decr_pulse || decr_held) hits++;
        end
        check_int("s1_pulse_count", q.size(), 7);
        for (int k = 0; k < 7; k++) begin
            check_int("s1_pulse_edge", (k < q.size()) ? q[k] : -1, exp_s1[k]);
        end
        check_int("s1_held_rise_edge", first_held, 11);
        check_int("s1_decr_quiet", hits, 0);
        idle(15);

        // 2: decrement bouncing every 3 cycles never qualifies
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            btn_decr_raw = ((i / 3) % 2 == 0);
            cycle();
            if (decr_pulse || decr_held) hits++;
        end
        btn_decr_raw = 0;
        idle(15);
        check_int("s2_decr_activity", hits, 0);
        check("s2_decr_held_idle", decr_held, 1'b0);

        // 3: held press with a 4-cycle glitch, then release
        base = now; hits = 0; held_drop = 0; fall_edge = -1;
        for (int i = 1; i <= 65; i++) begin
            btn_incr_raw = (i <= 50) && !(i >= 20 && i <= 23);
            cycle();
            if (incr_pulse) hits++;
            if (i >= 11 && i <= 52 && !incr_held) held_drop++;
            if (i > 52 && !incr_held && fall_edge < 0) fall_edge = i;
        end
        check_int("s3_pulse_count", hits, 1);
        check_int("s3_held_drops", held_drop, 0);
        check_int("s3_held_fall_edge", fall_edge, 53 + D);
        check("s3_held_released", incr_held, 1'b0);

        // 4: simultaneous press is fully suppressed
        hits = 0;
        btn_incr_raw = 1; btn_decr_raw = 1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (incr_pulse || decr_pulse) hits++;
        end
        check_int("s4_pulses", hits, 0);
        check("s4_incr_held", incr_held, 1'b1);
        check("s4_decr_held", decr_held, 1'b1);
        btn_incr_raw = 0; btn_decr_raw = 0;
        idle(15);

        // 6: reset in the middle of auto-repeat with the button still held
        btn_incr_raw = 1;
        idle(55);
        rst = 1;
        #1;
        model_reset();
        check("s6_rst_incr_pulse", incr_pulse, 1'b0);
        check("s6_rst_incr_held", incr_held, 1'b0);
        check("s6_rst_decr_pulse", decr_pulse, 1'b0);
        check("s6_rst_decr_held", decr_held, 1'b0);
        idle(2);
        rst = 0;
        base = now; first_pulse = -1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (incr_pulse && first_pulse < 0) first_pulse = now - base;
        end
        check_int("s6_first_pulse_after_rst", first_pulse, 11);
        btn_incr_raw = 0;
        idle(15);

        // 5: default parameters, repeat disabled, long hold
        d_repeat_en = 0; d_incr_raw = 1; base = now; d_cnt = 0; d_edge = -1; hits = 0;
        for (int i = 0; i < 10000; i++) begin
            cycle();
            if (d_incr_pulse) begin
                d_cnt++;
                if (d_edge < 0) d_edge = now - base;
            end
            if (d_decr_pulse || d_decr_held) hits++;
        end
        check_int("s5_pulse_count", d_cnt, 1);
        check_int("s5_pulse_edge", d_edge, 515);
        check_int("s5_decr_quiet", hits, 0);
        check("s5_held", d_incr_held, 1'b1);
        d_incr_raw = 0;
        idle(520);
        check("s5_released", d_incr_held, 1'b0);

        // Randomised segments checked against the model every cycle
        for (int s = 0; s < 60; s++) begin
            btn_incr_raw = ($urandom_range(0, 99) < 45);
            btn_decr_raw = ($urandom_range(0, 99) < 25);
            repeat_en    = ($urandom_range(0, 99) < 80);
            seg_len      = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6)
                                                       : $urandom_range(8, 70);
            idle(seg_len);
        end
        btn_incr_raw = 0; btn_decr_raw = 0;
        idle(20);
        check("end_incr_idle", incr_held, 1'b0);
        check("end_decr_idle", decr_held, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
